// File: rtl/wb_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wb_release_sequencer
// Description : Latches one writeback request (probe writeback or voluntary
//               release), reads the victim line beat-by-beat from the data
//               array and emits each beat on the C channel as ProbeAckData
//               or ReleaseData. Voluntary releases hold off new work until
//               the ReleaseAck arrives on the D channel.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_release_sequencer #(
    parameter int TAG_W  = 20,
    parameter int IDX_W  = 6,
    parameter int WAYS   = 8,
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int OFF_W  = 5
) (
    input  logic                            clock,
    input  logic                            reset_n,
    // Writeback request from the arbiter
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [TAG_W-1:0]                req_tag,
    input  logic [IDX_W-1:0]                req_idx,
    input  logic [2:0]                      req_param,
    input  logic [WAYS-1:0]                 req_way_en,
    input  logic                            req_voluntary,
    // Data-array read port
    output logic                            data_req_valid,
    input  logic                            data_req_ready,
    output logic [IDX_W+$clog2(BEATS)-1:0]  data_req_addr,
    output logic [WAYS-1:0]                 data_req_way_en,
    input  logic [BEAT_W-1:0]               data_resp_data,
    // C channel
    output logic                            rel_valid,
    input  logic                            rel_ready,
    output logic [2:0]                      rel_opcode,
    output logic [2:0]                      rel_param,
    output logic [TAG_W+IDX_W+OFF_W-1:0]    rel_addr,
    output logic [BEAT_W-1:0]               rel_data,
    output logic                            rel_last,
    // D channel ReleaseAck
    input  logic                            rel_ack_valid,
    // Status for set-conflict blocking
    output logic                            busy,
    output logic [IDX_W-1:0]                busy_idx
);

    localparam int BEAT_CNT_W = $clog2(BEATS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;

    localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [BEAT_CNT_W-1:0] beat_q;
    logic [TAG_W-1:0]      tag_q;
    logic [IDX_W-1:0]      idx_q;
    logic [2:0]            param_q;
    logic [WAYS-1:0]       way_q;
    logic                  vol_q;
    logic [BEAT_W-1:0]     buf_q;

    logic req_fire;
    logic rd_fire;
    logic rel_fire;
    logic last_beat;

    assign req_fire  = req_valid && (state_q == S_IDLE);
    assign rd_fire   = (state_q == S_READ) && data_req_ready;
    assign rel_fire  = (state_q == S_SEND) && rel_ready;
    assign last_beat = (beat_q == LAST_BEAT);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one read / capture / send round trip per beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_fire)      state_d = S_READ;
            S_READ: if (rd_fire)       state_d = S_CAPT;
            S_CAPT:                    state_d = S_SEND;
            S_SEND: if (rel_fire) begin
                if (!last_beat)        state_d = S_READ;
                else if (vol_q)        state_d = S_ACK;
                else                   state_d = S_IDLE;
            end
            S_ACK:  if (rel_ack_valid) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Request latch, beat counter and read-data buffer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q  <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            param_q <= '0;
            way_q   <= '0;
            vol_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            if (req_fire) begin
                tag_q   <= req_tag;
                idx_q   <= req_idx;
                param_q <= req_param;
                way_q   <= req_way_en;
                vol_q   <= req_voluntary;
            end
            // Read data is only valid the cycle after the read fired
            if (state_q == S_CAPT) begin
                buf_q <= data_resp_data;
            end
            if (rel_fire) begin
                beat_q <= last_beat ? '0 : beat_q + BEAT_CNT_W'(1);
            end
        end
    end

    // State-decoded outputs; beat fields are zero outside their valid window
    always_comb begin
        req_ready       = (state_q == S_IDLE);
        busy            = (state_q != S_IDLE);
        data_req_valid  = (state_q == S_READ);
        data_req_way_en = (state_q == S_READ) ? way_q : '0;
        rel_valid       = (state_q == S_SEND);
        rel_opcode      = 3'd0;
        rel_last        = 1'b0;
        if (state_q == S_SEND) begin
            rel_opcode = vol_q ? OP_RELEASE_DATA : OP_PROBE_ACK_DATA;
            rel_last   = last_beat;
        end
    end

    // Fields held in registers, hence stable across C-channel stalls
    assign data_req_addr = {idx_q, beat_q};
    assign rel_param     = param_q;
    assign rel_addr      = {tag_q, idx_q, {OFF_W{1'b0}}};
    assign rel_data      = buf_q;
    assign busy_idx      = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_release_sequencer
// Description : Self-checking bench for wb_release_sequencer. A transaction-
//               level model predicts every output each cycle; directed
//               sequences pin the model with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_release_sequencer;

    localparam int TAG_W  = 20;
    localparam int IDX_W  = 6;
    localparam int WAYS   = 8;
    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam int OFF_W  = 5;
    localparam int BW     = $clog2(BEATS);
    localparam int AW     = IDX_W + BW;
    localparam int RA     = TAG_W + IDX_W + OFF_W;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [IDX_W-1:0]  req_idx = '0;
    logic [2:0]        req_param = '0;
    logic [WAYS-1:0]   req_way_en = '0;
    logic              req_voluntary = 1'b0;
    logic              data_req_valid;
    logic              data_req_ready = 1'b0;
    logic [AW-1:0]     data_req_addr;
    logic [WAYS-1:0]   data_req_way_en;
    logic [BEAT_W-1:0] data_resp_data;
    logic              rel_valid;
    logic              rel_ready = 1'b0;
    logic [2:0]        rel_opcode;
    logic [2:0]        rel_param;
    logic [RA-1:0]     rel_addr;
    logic [BEAT_W-1:0] rel_data;
    logic              rel_last;
    logic              rel_ack_valid = 1'b0;
    logic              busy;
    logic [IDX_W-1:0]  busy_idx;

    wb_release_sequencer #(
        .TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS),
        .BEATS(BEATS), .BEAT_W(BEAT_W), .OFF_W(OFF_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_idx(req_idx), .req_param(req_param), .req_way_en(req_way_en),
        .req_voluntary(req_voluntary),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_addr(data_req_addr), .data_req_way_en(data_req_way_en),
        .data_resp_data(data_resp_data),
        .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_opcode(rel_opcode),
        .rel_param(rel_param), .rel_addr(rel_addr), .rel_data(rel_data),
        .rel_last(rel_last), .rel_ack_valid(rel_ack_valid),
        .busy(busy), .busy_idx(busy_idx)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line contents of the data array, unique per (address, way)
    function automatic logic [63:0] mem(input logic [AW-1:0] a, input logic [WAYS-1:0] w);
        logic [31:0] a32;
        a32 = 32'(a);
        return {a32 * 32'h9E3779B1, 24'hC0FFEE, 8'(w)};
    endfunction

    // Data-array model: correct data only the cycle after a read fires
    logic              rd_fire_prev = 1'b0;
    logic [AW-1:0]     rd_addr_prev = '0;
    logic [WAYS-1:0]   rd_way_prev  = '0;
    logic [63:0]       junk = 64'h0;
    always @(posedge clock) begin
        rd_fire_prev <= data_req_valid && data_req_ready;
        rd_addr_prev <= data_req_addr;
        rd_way_prev  <= data_req_way_en;
        junk         <= {$urandom, $urandom};
    end
    assign data_resp_data = rd_fire_prev ? mem(rd_addr_prev, rd_way_prev) : junk;

    // ---------------- transaction-level reference model ----------------
    int               cyc = 0;
    bit               m_active = 0;
    bit               m_wait_ack = 0;
    int               m_beat = 0;
    int               m_rd_cyc = -1;
    logic [TAG_W-1:0] m_tag = '0;
    logic [IDX_W-1:0] m_idx = '0;
    logic [2:0]       m_param = '0;
    logic [WAYS-1:0]  m_way = '0;
    bit               m_vol = 0;
    logic [IDX_W-1:0] m_busy_idx = '0;

    initial begin
        bit e_drv, e_rv, e_ack;
        logic [AW-1:0] e_addr;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_active = 0; m_wait_ack = 0; m_beat = 0; m_rd_cyc = -1;
                m_busy_idx = '0;
            end else begin
                e_ack  = m_active && m_wait_ack;
                e_drv  = m_active && !m_wait_ack && (m_rd_cyc < 0);
                e_rv   = m_active && !m_wait_ack && (m_rd_cyc >= 0) && (cyc >= m_rd_cyc + 2);
                e_addr = {m_idx, BW'(m_beat)};
                chk("req_ready", req_ready, !m_active);
                chk("busy", busy, m_active);
                chk("busy_idx", busy_idx, m_busy_idx);
                chk("data_req_valid", data_req_valid, e_drv);
                chk("data_req_way_en", data_req_way_en, e_drv ? m_way : '0);
                chk("rel_valid", rel_valid, e_rv);
                if (e_drv) chk("data_req_addr", data_req_addr, e_addr);
                if (e_rv) begin
                    chk("rel_opcode", rel_opcode, m_vol ? 3'd7 : 3'd5);
                    chk("rel_param", rel_param, m_param);
                    chk("rel_addr", rel_addr, {m_tag, m_idx, {OFF_W{1'b0}}});
                    chk("rel_data", rel_data, mem(e_addr, m_way));
                    chk("rel_last", rel_last, m_beat == BEATS - 1);
                end
                // Advance the model by at most one handshake this cycle
                if (!m_active && req_valid) begin
                    m_active = 1; m_wait_ack = 0; m_beat = 0; m_rd_cyc = -1;
                    m_tag = req_tag; m_idx = req_idx; m_param = req_param;
                    m_way = req_way_en; m_vol = req_voluntary; m_busy_idx = req_idx;
                end else if (e_drv && data_req_ready) begin
                    m_rd_cyc = cyc;
                end else if (e_rv && rel_ready) begin
                    if (m_beat == BEATS - 1) begin
                        m_beat = 0;
                        if (m_vol) m_wait_ack = 1;
                        else       m_active = 0;
                    end else begin
                        m_beat++;
                        m_rd_cyc = -1;
                    end
                end else if (e_ack && rel_ack_valid) begin
                    m_active = 0; m_wait_ack = 0;
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus and hand-computed checks ----------------
    initial begin
        int  nbeat;
        int  last_k;
        bit  found;

        // Reset state
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_busy_idx", busy_idx, 0);
        chk("rst_data_req_valid", data_req_valid, 0);
        chk("rst_data_req_way_en", data_req_way_en, 0);
        chk("rst_rel_valid", rel_valid, 0);
        chk("rst_rel_opcode", rel_opcode, 0);
        chk("rst_rel_addr", rel_addr, 0);
        chk("rst_rel_data", rel_data, 0);
        chk("rst_rel_last", rel_last, 0);
        step(); step();
        reset_n = 1'b1;
        step();

        // 1: probe writeback, no stalls
        req_valid = 1; req_tag = 20'h12345; req_idx = 6'h2A; req_param = 3'd1;
        req_way_en = 8'h04; req_voluntary = 0; rel_ready = 1; data_req_ready = 1;
        nbeat = 0; last_k = -1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (k == 0) chk("t1_accept", req_ready, 1);
            if (k == 1) chk("t1_rdaddr_first", data_req_addr, 8'hA8);
            if (k == 10) chk("t1_rdaddr_last", data_req_addr, 8'hAB);
            if (k == 3) begin
                chk("t1_rel_addr", rel_addr, 31'h091A2D40);
                chk("t1_opcode", rel_opcode, 3'd5);
                chk("t1_data0", rel_data, mem(8'hA8, 8'h04));
            end
            if (rel_valid && rel_ready) begin
                nbeat++;
                if (rel_last) last_k = k;
            end
            if (k == 12) chk("t1_ready_c12", req_ready, 0);
            if (k == 13) chk("t1_ready_c13", req_ready, 1);
            step();
            req_valid = 0;
        end
        chk("t1_beat_count", nbeat, 4);
        chk("t1_last_cycle", last_k, 12);

        // 2: voluntary release, ack 10 cycles after the last beat
        req_valid = 1; req_tag = 20'hABCDE; req_idx = 6'h11; req_param = 3'd2;
        req_way_en = 8'h80; req_voluntary = 1;
        step();
        req_valid = 0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rel_valid && rel_ready && rel_last) begin
                found = 1;
                chk("t2_opcode", rel_opcode, 3'd7);
                break;
            end
        end
        chk("t2_last_seen", found, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clock);
            chk("t2_wait_ready", req_ready, 0);
            chk("t2_wait_busy", busy, 1);
        end
        step();
        rel_ack_valid = 1;
        req_valid = 1; req_voluntary = 0; req_idx = 6'h05; req_way_en = 8'h01;
        @(negedge clock);
        chk("t2_ack_cycle_ready", req_ready, 0);
        step();
        rel_ack_valid = 0;
        @(negedge clock);
        chk("t2_after_ack_ready", req_ready, 1);
        step();

        // 3/4/5: random stalls, stray acks, req_valid held with new fields
        req_tag = 20'hFFFFF; req_idx = 6'h3F; req_param = 3'd7; req_way_en = 8'h40;
        for (int n = 0; n < 40; n++) begin
            data_req_ready = ($urandom_range(0, 2) == 0);
            rel_ready      = ($urandom_range(0, 2) == 0);
            rel_ack_valid  = $urandom_range(0, 1);
            step();
        end
        req_valid = 0;

        // Fully randomized traffic
        for (int n = 0; n < 2500; n++) begin
            req_valid      = ($urandom_range(0, 3) == 0);
            req_tag        = TAG_W'($urandom);
            req_idx        = IDX_W'($urandom);
            req_param      = 3'($urandom);
            req_way_en     = WAYS'(1) << $urandom_range(0, WAYS - 1);
            req_voluntary  = $urandom_range(0, 1);
            data_req_ready = ($urandom_range(0, 3) != 0);
            rel_ready      = ($urandom_range(0, 9) < 7);
            rel_ack_valid  = ($urandom_range(0, 4) == 0);
            step();
        end

        // 6: drain to idle, then reset during SEND of beat 2
        req_valid = 0; data_req_ready = 1; rel_ready = 1; rel_ack_valid = 1;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (req_ready) begin found = 1; break; end
        end
        chk("t6_drain_idle", found, 1);
        step();
        rel_ack_valid = 0;
        req_valid = 1; req_voluntary = 0; req_tag = 20'h0F0F0; req_idx = 6'h15;
        req_way_en = 8'h10; req_param = 3'd3;
        step();
        req_valid = 0;
        repeat (8) step();
        chk("t6_in_send", rel_valid, 1);
        chk("t6_beat2_data", rel_data, mem({6'h15, 2'd2}, 8'h10));
        reset_n = 0;
        #1;
        chk("t6_rst_req_ready", req_ready, 1);
        chk("t6_rst_rel_valid", rel_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rel_data", rel_data, 0);
        chk("t6_rst_rel_addr", rel_addr, 0);
        chk("t6_rst_busy_idx", busy_idx, 0);
        step();
        reset_n = 1;
        req_valid = 1; req_idx = 6'h15; req_way_en = 8'h10;
        step();
        req_valid = 0;
        @(negedge clock);
        chk("t6_restart_addr", data_req_addr, {6'h15, 2'd0});
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
